// File: rtl/prg_uploader.sv
// BASIC program uploader: captures the start/end pointers from RAM and serves the
// PRG file (2-byte load-address header + body) to the HPS. Optional macro PRG_UPLOADER_OVERRIDE_EN.
module prg_uploader #(
    parameter logic [15:0] PTR_BASE = 16'h002B
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        start,
    output logic [15:0] ram_addr,
    output logic        ram_rd,
    input  logic [7:0]  ram_din,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        busy,
    output logic        ready,
    output logic [16:0] len,
    output logic        error
`ifdef PRG_UPLOADER_OVERRIDE_EN
   ,input  logic        ovr_en,
    input  logic [15:0] ovr_start,
    input  logic [15:0] ovr_end
`endif
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned LW = 17;

    typedef enum logic [2:0] {
        S_IDLE, S_PTR, S_CHECK, S_READY, S_FETCH, S_WAIT
    } state_e;

    state_e          state_q;
    logic [2:0]      step_q;
    logic [AW-1:0]   start_ptr_q, end_ptr_q, ram_addr_q;
    logic            ram_rd_q, busy_q, ready_q, error_q, upload_q;
    logic [DW-1:0]   din_q;
    logic [LW-1:0]   len_q;
    logic [1:0]      run_q;

    logic            ovr_sel_c;
    logic [AW-1:0]   ovr_start_c, ovr_end_c;
    logic [AW-1:0]   fetch_addr_d;
    logic [LW-1:0]   len_d;
    logic            error_d;
    logic            past_end_c, start_ok_c, upload_fall_c;

`ifdef PRG_UPLOADER_OVERRIDE_EN
    assign ovr_sel_c   = ovr_en;
    assign ovr_start_c = ovr_start;
    assign ovr_end_c   = ovr_end;
`else
    assign ovr_sel_c   = 1'b0;
    assign ovr_start_c = '0;
    assign ovr_end_c   = '0;
`endif

    // Address arithmetic, length check and request qualification
    always_comb begin
        fetch_addr_d  = start_ptr_q + ioctl_addr[AW-1:0] - AW'(2);
        error_d       = 1'b0;
        len_d         = LW'(2);
        if (end_ptr_q < start_ptr_q) begin
            error_d = 1'b1;
        end else begin
            len_d = {1'b0, end_ptr_q} - {1'b0, start_ptr_q} + LW'(2);
        end
        past_end_c    = ioctl_addr >= {8'd0, len_q};
        start_ok_c    = start && run_q[1] && (state_q == S_IDLE || state_q == S_READY);
        upload_fall_c = upload_q && !ioctl_upload;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            start_ptr_q <= '0;
            end_ptr_q   <= '0;
            ram_addr_q  <= '0;
            ram_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            upload_q    <= 1'b0;
            din_q       <= '0;
            len_q       <= '0;
            run_q       <= '0;
        end else begin
            upload_q <= ioctl_upload;
            // start is only honoured once reset release has propagated for two cycles
            run_q    <= {run_q[0], 1'b1};
            if (upload_fall_c) begin
                state_q  <= S_IDLE;
                ready_q  <= 1'b0;
                busy_q   <= 1'b0;
                ram_rd_q <= 1'b0;
            end else if (start_ok_c) begin
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
                step_q  <= '0;
                if (ovr_sel_c) begin
                    start_ptr_q <= ovr_start_c;
                    end_ptr_q   <= ovr_end_c;
                    state_q     <= S_CHECK;
                end else begin
                    ram_rd_q   <= 1'b1;
                    ram_addr_q <= PTR_BASE;
                    state_q    <= S_PTR;
                end
            end else begin
                case (state_q)
                    S_PTR: begin
                        // even steps: read strobe is out; odd steps: data is back
                        if (!step_q[0]) begin
                            ram_rd_q <= 1'b0;
                            step_q   <= step_q + 3'd1;
                        end else begin
                            case (step_q[2:1])
                                2'd0:    start_ptr_q[7:0]  <= ram_din;
                                2'd1:    start_ptr_q[15:8] <= ram_din;
                                2'd2:    end_ptr_q[7:0]    <= ram_din;
                                default: end_ptr_q[15:8]   <= ram_din;
                            endcase
                            if (step_q == 3'd7) begin
                                state_q <= S_CHECK;
                            end else begin
                                ram_rd_q   <= 1'b1;
                                ram_addr_q <= PTR_BASE + AW'(step_q[2:1]) + AW'(1);
                                step_q     <= step_q + 3'd1;
                            end
                        end
                    end
                    S_CHECK: begin
                        len_q   <= len_d;
                        error_q <= error_d;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_READY;
                    end
                    S_READY: begin
                        if (ioctl_rd) begin
                            if (ioctl_addr < 25'd2) begin
                                din_q <= ioctl_addr[0] ? start_ptr_q[15:8] : start_ptr_q[7:0];
                            end else begin
                                ram_addr_q <= fetch_addr_d;
                                if (past_end_c) begin
                                    din_q <= '0;
                                end else begin
                                    ram_rd_q <= 1'b1;
                                    busy_q   <= 1'b1;
                                    state_q  <= S_FETCH;
                                end
                            end
                        end
                    end
                    S_FETCH: begin
                        ram_rd_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= S_WAIT;
                    end
                    S_WAIT: begin
                        din_q   <= ram_din;
                        state_q <= S_READY;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_rd    = ram_rd_q;
    // RAM data is forwarded while it arrives so a fetched byte meets the 2-cycle turnaround
    assign ioctl_din = (state_q == S_WAIT) ? ram_din : din_q;
    assign busy      = busy_q;
    assign ready     = ready_q;
    assign len       = len_q;
    assign error     = error_q;

endmodule

// File: doc/prg_uploader.md
PRG_UPLOADER -- requirements
Module: prg_uploader

Interface
REQ-001 SHALL have parameter PTR_BASE, default 16'h002B: RAM address of the BASIC start pointer (lo, hi); the end pointer follows at PTR_BASE+2 and PTR_BASE+3.
REQ-002 SHALL have port clk_sys, input, 1 bit: the only clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: single-cycle request to capture the program pointers.
REQ-005 SHALL have port ram_addr, output, 16 bits: main RAM read address.
REQ-006 SHALL have port ram_rd, output, 1 bit: RAM read strobe.
REQ-007 SHALL have port ram_din, input, 8 bits: RAM data, valid exactly 1 cycle after ram_rd.
REQ-008 SHALL have port ioctl_upload, input, 1 bit: HPS upload session active.
REQ-009 SHALL have port ioctl_rd, input, 1 bit: HPS byte request, one-cycle pulse.
REQ-010 SHALL have port ioctl_addr, input, 25 bits: file offset of the requested byte.
REQ-011 SHALL have port ioctl_din, output, 8 bits: byte returned to HPS.
REQ-012 SHALL have port busy, output, 1 bit: capture or fetch in progress.
REQ-013 SHALL have port ready, output, 1 bit: pointers captured, upload may proceed.
REQ-014 SHALL have port len, output, 17 bits: file length in bytes, header included.
REQ-015 SHALL have port error, output, 1 bit: end pointer < start pointer.

Function
REQ-016 SHALL implement states IDLE, PTR (4 sequential reads), CHECK, READY, FETCH, WAIT.
REQ-017 SHALL transition IDLE->PTR on start; PTR->CHECK after 4 reads; CHECK->READY after one cycle.
REQ-018 In PTR, SHALL issue one ram_rd per 2 cycles at PTR_BASE..PTR_BASE+3, latching start_ptr and end_ptr.
REQ-019 In CHECK, SHALL compute len = end_ptr - start_ptr + 2 in 17 bits; if end_ptr < start_ptr, SHALL set error=1 and len=2.
REQ-020 In READY with ioctl_rd: for ioctl_addr 0 SHALL present start_ptr[7:0], for 1 SHALL present start_ptr[15:8]; either SHALL be valid on ioctl_din 2 cycles after ioctl_rd.
REQ-021 In READY with ioctl_rd and ioctl_addr>=2, SHALL go to FETCH and read RAM at start_ptr + ioctl_addr - 2 (16-bit wrap); ioctl_din SHALL be valid 2 cycles after ioctl_rd; SHALL then return to READY.
REQ-022 For ioctl_addr >= len, SHALL return 8'h00 without a RAM read.
REQ-023 SHALL ignore an ioctl_rd arriving while in FETCH or WAIT; HPS spacing is at least 3 cycles.
REQ-024 SHALL ignore start when not in IDLE or READY; start in READY SHALL recapture the pointers (READY->PTR).
REQ-025 A falling edge of ioctl_upload SHALL return the block to IDLE, with ready=0 and error retained.
REQ-026 ioctl_din SHALL hold its last value between requests.
REQ-027 busy SHALL be 1 in PTR, CHECK and FETCH, and 0 otherwise.

Reset
REQ-028 On reset, SHALL enter IDLE with ram_rd=0, ram_addr=0, ioctl_din=0, busy=0, ready=0, len=0, error=0 and pointers=0, regardless of any operation in progress.
REQ-029 SHALL leave reset synchronously to clk_sys; the first start SHALL be honoured no earlier than the 2nd cycle after deassertion.

Configuration
REQ-030 With macro PRG_UPLOADER_OVERRIDE_EN defined, SHALL add inputs ovr_en (1 bit), ovr_start (16 bits) and ovr_end (16 bits); start with ovr_en=1 SHALL skip PTR, load the pointers from these inputs and go directly to CHECK.
REQ-031 Without PRG_UPLOADER_OVERRIDE_EN, those ports SHALL be absent and the pointers SHALL always come from RAM.

Verification
REQ-032 RAM[$2B..$2E]=01,10,21,10; start -> ready after PTR+CHECK; len=17'h22, error=0.
REQ-033 After REQ-032, ioctl_rd with addr 0,1,2 -> ioctl_din=01, 10, then RAM[$1001]; each 2 cycles after its ioctl_rd.
REQ-034 Pointers start=$1001, end=$1000 -> error=1, len=2; ioctl_rd at addr 2 -> 00 with no ram_rd.
REQ-035 start=$FFFF, end=$FFFF; ioctl_rd at addr 3 -> ram_addr=$0000 (wrap).
REQ-036 Assert reset during FETCH -> next cycle: IDLE, ready=0, ram_rd=0, ioctl_din=0.
REQ-037 With PRG_UPLOADER_OVERRIDE_EN: ovr_en=1, ovr_start=$2000, ovr_end=$20FF, start -> no ram_rd during capture; len=$101.
